// File: rtl/pmem_rr_arbiter.sv
// rtl/pmem_rr_arbiter.sv - registered round-robin arbiter sharing one pmem port between I-cache and D-cache
//
// Purpose:
//   Arbitrates the single physical-memory port between the instruction cache
//   (read only) and the data cache (read or writeback). The winning request's
//   address, write line and op are latched at grant so memory sees stable
//   inputs. Read data returns through per-side registers with a one-cycle
//   resp pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ipmem_address/read        I-cache request (level, held until ipmem_resp)
//   ipmem_rdata/resp          I-cache returned line and completion pulse
//   dpmem_address/wdata       D-cache request address and writeback line
//   dpmem_read/write          D-cache request (write wins if both high)
//   dpmem_rdata/resp          D-cache returned line and completion pulse
//   pmem_address/wdata        latched address and write line to memory
//   pmem_read/write           memory strobes, high for the whole BUSY state
//   pmem_rdata/resp           memory returned line and completion
//
// Optional feature (macro ARB_PERF_CNT_EN):
//   Adds parameter CNT_W and outputs i_grant_cnt, d_grant_cnt, conflict_cnt,
//   all saturating counters cleared by rst.

module pmem_rr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
`ifdef ARB_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ipmem_address,
    input  logic              ipmem_read,
    output logic [LINE_W-1:0] ipmem_rdata,
    output logic              ipmem_resp,

    input  logic [ADDR_W-1:0] dpmem_address,
    input  logic [LINE_W-1:0] dpmem_wdata,
    input  logic              dpmem_read,
    input  logic              dpmem_write,
    output logic [LINE_W-1:0] dpmem_rdata,
    output logic              dpmem_resp,

    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_I,
        S_BUSY_D,
        S_DONE_I,
        S_DONE_D
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              w_req_i;
    logic              w_req_d;
    logic              w_grant_i;
    logic              w_grant_d;

    // r_last_d = 1 means the last grant went to D, so I wins the next tie.
    logic              r_last_d;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_op_write;
    logic [LINE_W-1:0] r_irdata;
    logic [LINE_W-1:0] r_drdata;

    assign w_req_i = ipmem_read;
    assign w_req_d = dpmem_read | dpmem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_i && (!w_req_d || r_last_d)) begin
                    w_grant_i = 1'b1;
                    w_next    = S_BUSY_I;
                end else if (w_req_d) begin
                    w_grant_d = 1'b1;
                    w_next    = S_BUSY_D;
                end
            end
            S_BUSY_I: begin
                if (pmem_resp) begin
                    w_next = S_DONE_I;
                end
            end
            S_BUSY_D: begin
                if (pmem_resp) begin
                    w_next = S_DONE_D;
                end
            end
            S_DONE_I: w_next = S_IDLE;
            S_DONE_D: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d   <= 1'b1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_op_write <= 1'b0;
            r_irdata   <= '0;
            r_drdata   <= '0;
        end else begin
            if (w_grant_i) begin
                r_addr     <= ipmem_address;
                r_op_write <= 1'b0;
                r_last_d   <= 1'b0;
            end else if (w_grant_d) begin
                r_addr     <= dpmem_address;
                r_wdata    <= dpmem_wdata;
                // Write takes precedence; a simultaneous read is dropped.
                r_op_write <= dpmem_write;
                r_last_d   <= 1'b1;
            end
            if (r_state == S_BUSY_I && pmem_resp) begin
                r_irdata <= pmem_rdata;
            end
            if (r_state == S_BUSY_D && pmem_resp) begin
                r_drdata <= pmem_rdata;
            end
        end
    end

    // Strobes and resps decode the registered state only, so nothing on the
    // requester side depends combinationally on pmem_resp.
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign pmem_read    = (r_state == S_BUSY_I) || (r_state == S_BUSY_D && !r_op_write);
    assign pmem_write   = (r_state == S_BUSY_D) && r_op_write;
    assign ipmem_rdata  = r_irdata;
    assign dpmem_rdata  = r_drdata;
    assign ipmem_resp   = (r_state == S_DONE_I);
    assign dpmem_resp   = (r_state == S_DONE_D);

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] r_i_cnt;
    logic [CNT_W-1:0] r_d_cnt;
    logic [CNT_W-1:0] r_c_cnt;
    logic             w_conflict;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A conflict cycle is one where a side is waiting while the other side
    // owns the port (its BUSY or DONE state).
    assign w_conflict = (w_req_d && (r_state == S_BUSY_I || r_state == S_DONE_I)) ||
                        (w_req_i && (r_state == S_BUSY_D || r_state == S_DONE_D));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_cnt <= '0;
            r_d_cnt <= '0;
            r_c_cnt <= '0;
        end else begin
            if (w_grant_i && r_i_cnt != '1) begin
                r_i_cnt <= r_i_cnt + CNT_ONE;
            end
            if (w_grant_d && r_d_cnt != '1) begin
                r_d_cnt <= r_d_cnt + CNT_ONE;
            end
            if (w_conflict && r_c_cnt != '1) begin
                r_c_cnt <= r_c_cnt + CNT_ONE;
            end
        end
    end

    assign i_grant_cnt  = r_i_cnt;
    assign d_grant_cnt  = r_d_cnt;
    assign conflict_cnt = r_c_cnt;
`endif

endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// tb/tb_pmem_rr_arbiter.sv - directed self-checking bench for pmem_rr_arbiter

module tb_pmem_rr_arbiter;

    logic         clk;
    logic         rst;
    logic [31:0]  ipmem_address;
    logic         ipmem_read;
    logic [255:0] ipmem_rdata;
    logic         ipmem_resp;
    logic [31:0]  dpmem_address;
    logic [255:0] dpmem_wdata;
    logic         dpmem_read;
    logic         dpmem_write;
    logic [255:0] dpmem_rdata;
    logic         dpmem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]  i_grant_cnt;
    logic [31:0]  d_grant_cnt;
    logic [31:0]  conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pmem_rr_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ipmem_address (ipmem_address),
        .ipmem_read    (ipmem_read),
        .ipmem_rdata   (ipmem_rdata),
        .ipmem_resp    (ipmem_resp),
        .dpmem_address (dpmem_address),
        .dpmem_wdata   (dpmem_wdata),
        .dpmem_read    (dpmem_read),
        .dpmem_write   (dpmem_write),
        .dpmem_rdata   (dpmem_rdata),
        .dpmem_resp    (dpmem_resp),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
`ifdef ARB_PERF_CNT_EN
        ,
        .i_grant_cnt   (i_grant_cnt),
        .d_grant_cnt   (d_grant_cnt),
        .conflict_cnt  (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        ipmem_address = '0;
        ipmem_read    = 1'b0;
        dpmem_address = '0;
        dpmem_wdata   = '0;
        dpmem_read    = 1'b0;
        dpmem_write   = 1'b0;
        pmem_rdata    = '0;
        pmem_resp     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Entered in the IDLE cycle where the request is visible; returns in the
    // DONE cycle. Memory raises pmem_resp lat cycles after the first strobe.
    task automatic txn(input string tag, input logic is_d, input logic is_wr,
                       input logic [31:0] addr, input logic [255:0] wd,
                       input logic [255:0] rd, input int lat, input logic chg);
        tick();
        for (int i = 0; i <= lat; i++) begin
            chk({tag, " pmem_read"},  pmem_read,  !is_wr);
            chk({tag, " pmem_write"}, pmem_write, is_wr);
            chk({tag, " pmem_addr"},  pmem_address, addr);
            if (is_wr) chk({tag, " pmem_wdata"}, pmem_wdata, wd);
            chk({tag, " iresp busy"}, ipmem_resp, 1'b0);
            chk({tag, " dresp busy"}, dpmem_resp, 1'b0);
            if (chg && i == 0) begin
                dpmem_address = 32'h0000_00C0;
                dpmem_wdata   = '0;
            end
            if (i == lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rd;
            end
            tick();
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        chk({tag, " iresp done"}, ipmem_resp, !is_d);
        chk({tag, " dresp done"}, dpmem_resp, is_d);
        chk({tag, " strobes off"}, {pmem_read, pmem_write}, 2'b00);
        if (!is_wr) begin
            if (is_d) chk({tag, " drdata"}, dpmem_rdata, rd);
            else      chk({tag, " irdata"}, ipmem_rdata, rd);
        end
    endtask

    logic [255:0] line_a5;
    logic [255:0] line_w1;
    logic [255:0] line_w2;
    logic [255:0] line_i1;
    logic [255:0] line_i2;
    logic [255:0] line_d1;

    initial begin
        line_a5 = {8{32'hA5A5_A5A5}};
        line_w1 = {8{32'h1234_5678}};
        line_w2 = {8{32'hCAFE_0080}};
        line_i1 = {8{32'h1111_0001}};
        line_i2 = {8{32'h2222_0002}};
        line_d1 = {8{32'h3333_0003}};

        // Reset state
        do_reset();
        chk("rst pmem_read",  pmem_read,  1'b0);
        chk("rst pmem_write", pmem_write, 1'b0);
        chk("rst iresp",      ipmem_resp, 1'b0);
        chk("rst dresp",      dpmem_resp, 1'b0);
        chk("rst pmem_addr",  pmem_address, 32'h0);
        chk("rst pmem_wdata", pmem_wdata, 256'h0);
        chk("rst irdata",     ipmem_rdata, 256'h0);
        chk("rst drdata",     dpmem_rdata, 256'h0);

        // Single I-cache read, memory latency 3
        ipmem_address = 32'h0000_0040;
        ipmem_read    = 1'b1;
        txn("t1 iread", 1'b0, 1'b0, 32'h40, '0, line_a5, 3, 1'b0);
        ipmem_read = 1'b0;
        tick();
        chk("t1 iresp pulse end", ipmem_resp, 1'b0);
        chk("t1 irdata held",     ipmem_rdata, line_a5);
        chk("t1 dresp quiet",     dpmem_resp, 1'b0);
        chk("t1 idle strobe",     pmem_read, 1'b0);

        // Both held from reset: grants alternate I, D, I, D
        do_reset();
        ipmem_address = 32'h0000_0100;
        ipmem_read    = 1'b1;
        dpmem_address = 32'h0000_0200;
        dpmem_wdata   = line_w1;
        dpmem_write   = 1'b1;
        txn("t2 I#1", 1'b0, 1'b0, 32'h100, '0, line_i1, 2, 1'b0);
        tick();
        chk("t2 gap strobes", {pmem_read, pmem_write}, 2'b00);
        txn("t2 D#1", 1'b1, 1'b1, 32'h200, line_w1, '0, 1, 1'b0);
        tick();
        txn("t2 I#2", 1'b0, 1'b0, 32'h100, '0, line_i2, 2, 1'b0);
        tick();
        txn("t2 D#2", 1'b1, 1'b1, 32'h200, line_w1, '0, 1, 1'b0);
        ipmem_read  = 1'b0;
        dpmem_write = 1'b0;
        tick();

        // D write whose inputs change after grant
        dpmem_address = 32'h0000_0080;
        dpmem_wdata   = line_w2;
        dpmem_write   = 1'b1;
        txn("t3 dwr latch", 1'b1, 1'b1, 32'h80, line_w2, '0, 2, 1'b1);
        dpmem_write = 1'b0;
        tick();
        chk("t3 irdata untouched", ipmem_rdata, line_i2);

        // D read and write together: write only
        dpmem_address = 32'h0000_0180;
        dpmem_wdata   = line_w1;
        dpmem_read    = 1'b1;
        dpmem_write   = 1'b1;
        txn("t5 rd+wr", 1'b1, 1'b1, 32'h180, line_w1, '0, 1, 1'b0);
        dpmem_read  = 1'b0;
        dpmem_write = 1'b0;
        tick();

        // Reset in BUSY_I with pmem_resp in the same cycle
        ipmem_address = 32'h0000_0300;
        ipmem_read    = 1'b1;
        tick();
        chk("t4 busy_i strobe", pmem_read, 1'b1);
        rst        = 1'b1;
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'hFFFF_FFFF}};
        ipmem_read = 1'b0;
        tick();
        rst        = 1'b0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        chk("t4 strobes dropped", {pmem_read, pmem_write}, 2'b00);
        chk("t4 no iresp",        ipmem_resp, 1'b0);
        chk("t4 irdata cleared",  ipmem_rdata, 256'h0);
        chk("t4 addr cleared",    pmem_address, 32'h0);
        tick();
        chk("t4 still no iresp",  ipmem_resp, 1'b0);
        chk("t4 idle strobe",     pmem_read, 1'b0);
        ipmem_address = 32'h0000_0340;
        ipmem_read    = 1'b1;
        dpmem_address = 32'h0000_0380;
        dpmem_read    = 1'b1;
        txn("t4 I first", 1'b0, 1'b0, 32'h340, '0, line_i1, 1, 1'b0);
        tick();
        txn("t4 D next", 1'b1, 1'b0, 32'h380, '0, line_d1, 1, 1'b0);
        ipmem_read = 1'b0;
        dpmem_read = 1'b0;
        tick();

`ifdef ARB_PERF_CNT_EN
        // Performance counters with two conflicting requests
        do_reset();
        chk("pc rst conflict", conflict_cnt, 32'd0);
        ipmem_address = 32'h0000_0400;
        ipmem_read    = 1'b1;
        dpmem_address = 32'h0000_0440;
        dpmem_read    = 1'b1;
        txn("pc I", 1'b0, 1'b0, 32'h400, '0, line_i1, 3, 1'b0);
        ipmem_read = 1'b0;
        tick();
        chk("pc conflict after I", conflict_cnt, 32'd5);
        chk("pc i_grant",          i_grant_cnt,  32'd1);
        chk("pc d_grant before",   d_grant_cnt,  32'd0);
        txn("pc D", 1'b1, 1'b0, 32'h440, '0, line_d1, 3, 1'b0);
        dpmem_read = 1'b0;
        tick();
        chk("pc i_grant end",  i_grant_cnt,  32'd1);
        chk("pc d_grant end",  d_grant_cnt,  32'd1);
        chk("pc conflict end", conflict_cnt, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_rr_arbiter.md
Name: pmem_rr_arbiter

Overview:
Registered round-robin arbiter that shares the single physical-memory port between the instruction cache and the data cache.
- Latches the winning request (address, write data, op) at grant time, so the memory sees stable inputs even if the requester changes its outputs.
- Returns read data through a register with a one-cycle response pulse.
- Sits between the two caches and the cacheline adaptor / main memory.

Parameters:
ADDR_W, 32, address width.
LINE_W, 256, cache line width in bits.
CNT_W, 32, width of performance counters (used only with ARB_PERF_CNT_EN).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ipmem_address  input  ADDR_W  I-cache line address
ipmem_read  input  1  I-cache read request, level, held until ipmem_resp
ipmem_rdata  output  LINE_W  I-cache read line
ipmem_resp  output  1  I-cache one-cycle completion pulse
dpmem_address  input  ADDR_W  D-cache line address
dpmem_wdata  input  LINE_W  D-cache writeback line
dpmem_read  input  1  D-cache read request
dpmem_write  input  1  D-cache write request
dpmem_rdata  output  LINE_W  D-cache read line
dpmem_resp  output  1  D-cache one-cycle completion pulse
pmem_address  output  ADDR_W  memory address (latched)
pmem_wdata  output  LINE_W  memory write line (latched)
pmem_read  output  1  memory read strobe
pmem_write  output  1  memory write strobe
pmem_rdata  input  LINE_W  memory read line
pmem_resp  input  1  memory completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE; priority pointer favours I-cache.
  - All resp/read/write outputs 0; pmem_address 0; pmem_wdata 0; rdata registers 0.
  - Reset asserted mid-transaction drops pmem_read/pmem_write at that edge. The in-flight pmem_resp is ignored and no requester resp is produced.
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE:
  - I request = ipmem_read. D request = dpmem_read | dpmem_write.
  - Only one request pending: grant it.
  - Both pending: grant the side not granted last (pointer). After reset, I wins.
  - On grant, register address, dpmem_wdata (D only) and op. Write has precedence if dpmem_read and dpmem_write are both high; the read is dropped. Update the pointer.
- BUSY_x:
  - pmem_read/pmem_write are driven from the latched op; pmem_address/pmem_wdata come from the latched registers.
  - Hold until pmem_resp. On the pmem_resp cycle, capture pmem_rdata into the granted side's rdata register and go to DONE_x.
  - Strobes deassert on the edge following pmem_resp.
- DONE_x:
  - Assert ipmem_resp or dpmem_resp for exactly one cycle; rdata is valid that cycle and held afterwards.
  - Next state is IDLE. A request still high in IDLE is treated as new, so requesters must drop the request after resp.
- Latency:
  - Request seen in IDLE at cycle 0 → strobe at cycle 1.
  - pmem_resp at cycle k → requester resp at cycle k+1.
  - Back-to-back: new grant no earlier than 1 cycle after DONE.
- Fairness: with both sides continuously requesting, grants strictly alternate. The maximum wait is one full transaction of the other side.
- Request withdrawn while BUSY: no effect; the transaction completes using latched values and resp is still pulsed.
- ipmem_rdata and dpmem_rdata are independent registers; a D transaction never alters ipmem_rdata.
- No combinational path from pmem_resp to any requester output.

Optional Feature:
Macro ARB_PERF_CNT_EN.
- Defined: adds output ports i_grant_cnt, d_grant_cnt and conflict_cnt (each CNT_W wide).
  - i_grant_cnt and d_grant_cnt increment per grant.
  - conflict_cnt increments for every cycle in which a requester has a pending request but is not the side in BUSY/DONE.
  - All counters saturate at all-ones, clear on rst and are 0 after reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- After reset, assert ipmem_read with addr 0x0000_0040; memory responds 3 cycles after strobe with line 0xA5..A5. Expect pmem_read=1, pmem_address=0x40, then ipmem_resp pulse one cycle after pmem_resp with ipmem_rdata=0xA5..A5; dpmem_resp stays 0.
- ipmem_read and dpmem_write asserted together from reset, then held. Expect grant order I, D, I, D; the D write shows pmem_write=1 with latched wdata 0x1234...; no pmem_read in the D slot.
- D write of addr 0x80; after grant, change dpmem_address to 0xC0 and dpmem_wdata to 0. Expect pmem_address to stay 0x80 with the original wdata until pmem_resp.
- Assert rst in BUSY_I with pmem_resp arriving the same cycle. Expect all strobes 0 next cycle, no ipmem_resp, state IDLE, and I wins the next simultaneous request.
- dpmem_read and dpmem_write both high. Expect only pmem_write=1.
- With ARB_PERF_CNT_EN: two conflicting requests of 3-cycle memory latency. Expect i_grant_cnt=1, d_grant_cnt=1, and conflict_cnt equal to the D wait cycles (5).
